// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and state encoding for the cache block fill controller.
package cache_fill_ctrl_pkg;

    localparam int unsigned AddrWidth     = 16;
    localparam int unsigned WordsPerBlock = 8;
    localparam int unsigned OffsetBits    = 4;
    localparam int unsigned WordIdxBits   = $clog2(WordsPerBlock);
    // One extra bit so the counters can hold the saturated value WordsPerBlock.
    localparam int unsigned CntWidth      = WordIdxBits + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StTag  = 2'd2
    } fill_state_e;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for a block fill: async reset, enable, sync clear, saturates at MaxCount.
module fill_word_counter #(
    parameter int unsigned Width    = 4,
    parameter int unsigned MaxCount = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [Width-1:0] cnt
);

    logic [Width-1:0] cnt_q;

    // Count enabled events; clear wins over enable; hold once MaxCount is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != Width'(MaxCount))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: issues 8 pipelined word reads for the missing block,
// writes each returned word into the data array, then pulses the tag write.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_detected,
    input  logic [AddrWidth-1:0]   miss_address,
    output logic                   fsm_busy,
    output logic                   memory_enable,
    output logic                   memory_wr,
    output logic [AddrWidth-1:0]   memory_address,
    input  logic [15:0]            memory_data,
    input  logic                   memory_data_valid,
    output logic                   write_data_array,
    output logic [WordIdxBits-1:0] fill_word,
    output logic [15:0]            fill_data,
    output logic                   write_tag_array,
    output logic                   proto_err
);

    fill_state_e                      state_q;
    logic [AddrWidth-1:OffsetBits]    base_q;
    logic                             proto_err_q;
    logic [CntWidth-1:0]              req_cnt;
    logic [CntWidth-1:0]              rsp_cnt;
    logic                             req_fire;
    logic                             rsp_fire;
    logic                             cnt_clr;
    logic                             unused_miss_offset;

    // The block base drops the byte offset, so the miss offset bits are never stored.
    assign unused_miss_offset = ^miss_address[OffsetBits-1:0];

    assign req_fire = (state_q == StFill) && (req_cnt != CntWidth'(WordsPerBlock));
    // A response is only accepted against an outstanding request.
    assign rsp_fire = memory_data_valid && (state_q == StFill) && (rsp_cnt != req_cnt);
    assign cnt_clr  = (state_q == StTag);

    fill_word_counter #(
        .Width    (CntWidth),
        .MaxCount (WordsPerBlock)
    ) u_req_cnt (
        .clk (clk),
        .rst (rst),
        .en  (req_fire),
        .clr (cnt_clr),
        .cnt (req_cnt)
    );

    fill_word_counter #(
        .Width    (CntWidth),
        .MaxCount (WordsPerBlock)
    ) u_rsp_cnt (
        .clk (clk),
        .rst (rst),
        .en  (rsp_fire),
        .clr (cnt_clr),
        .cnt (rsp_cnt)
    );

    // State, block base and sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (memory_data_valid && !rsp_fire) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (miss_detected) begin
                        base_q  <= miss_address[AddrWidth-1:OffsetBits];
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (rsp_fire && (rsp_cnt == CntWidth'(WordsPerBlock - 1))) begin
                        state_q <= StTag;
                    end
                end
                StTag:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode; busy includes the miss cycle so the cache stalls immediately.
    always_comb begin
        fsm_busy         = rst && ((state_q != StIdle) || miss_detected);
        memory_enable    = req_fire;
        memory_wr        = 1'b0;
        memory_address   = '0;
        if (req_fire) begin
            memory_address = {base_q, req_cnt[WordIdxBits-1:0], 1'b0};
        end
        write_data_array = rsp_fire;
        fill_word        = '0;
        fill_data        = '0;
        if (rsp_fire) begin
            fill_word = rsp_cnt[WordIdxBits-1:0];
            fill_data = memory_data;
        end
        write_tag_array  = (state_q == StTag);
        proto_err        = proto_err_q;
    end

endmodule
